// File: rtl/corefifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO controller and its RAM.
package corefifo_pkg;

  localparam int DEF_ADDR_W     = 10;
  localparam int DEF_AEMPTY_VAL = 4;
  localparam int DEF_AFULL_VAL  = 1020;

  // Pointers carry one extra wrap bit above the RAM address.
  function automatic int ptr_width(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  localparam int DEF_PTR_W = DEF_ADDR_W + 1;

endpackage

// File: rtl/corefifo_sdp_ram.sv
// Simple-dual-port RAM: synchronous write, read-first synchronous read with a
// registered, enable-gated output that clears on reset.
module corefifo_sdp_ram
  import corefifo_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 1024,
  localparam int AW = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Output register holds its value between accepted reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/corefifo_sync_ctrl.sv
// Single-clock FIFO controller feeding an FWFT output stage: pointers, count,
// status flags and overflow/underflow pulses around an SDP RAM.
module corefifo_sync_ctrl
  import corefifo_pkg::*;
#(
  parameter int WIDTH      = 10,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int AEMPTY_VAL = DEF_AEMPTY_VAL,
  parameter int AFULL_VAL  = DEF_AFULL_VAL,
  parameter int WRITE_LOW  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  din,
  input  logic              fifo_rd_en,
  output logic [WIDTH-1:0]  fifo_dout,
  output logic              fifo_empty,
  output logic              fifo_aempty,
  output logic              full,
  output logic              afull,
  output logic [ADDR_W-1:0] fifo_MEMRADDR,
  output logic [ADDR_W:0]   wr_count,
  output logic              overflow,
  output logic              underflow
);

  localparam int PW    = ptr_width(ADDR_W);
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [PW-1:0] FULL_CNT   = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_CNT  = PW'(AFULL_VAL);
  localparam logic [PW-1:0] AEMPTY_CNT = PW'(AEMPTY_VAL);
  localparam logic [PW-1:0] ONE        = PW'(1);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] count;
  logic          wr_req;
  logic          we_acc;
  logic          re_acc;

  assign wr_req = (WRITE_LOW != 0) ? ~wr_en : wr_en;
  assign we_acc = wr_req & ~full;
  assign re_acc = fifo_rd_en & ~fifo_empty;

  // Flags come straight from the count register, so they lag the event by one edge.
  assign fifo_empty    = (count == '0);
  assign fifo_aempty   = (count <= AEMPTY_CNT);
  assign full          = (count == FULL_CNT);
  assign afull         = (count >= AFULL_CNT);
  assign wr_count      = count;
  assign fifo_MEMRADDR = rd_ptr[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (we_acc) begin
        wr_ptr <= wr_ptr + ONE;
      end
      if (re_acc) begin
        rd_ptr <= rd_ptr + ONE;
      end
      if (we_acc && !re_acc) begin
        count <= count + ONE;
      end else if (re_acc && !we_acc) begin
        count <= count - ONE;
      end
      overflow  <= wr_req & full;
      underflow <= fifo_rd_en & fifo_empty;
    end
  end

  corefifo_sdp_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk),
    .reset(reset),
    .we   (we_acc),
    .waddr(wr_ptr[ADDR_W-1:0]),
    .wdata(din),
    .re   (re_acc),
    .raddr(rd_ptr[ADDR_W-1:0]),
    .rdata(fifo_dout)
  );

endmodule

// File: tb/tb_corefifo_sync_ctrl.sv
// Self-checking bench for corefifo_sync_ctrl: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based FIFO model.
module tb_corefifo_sync_ctrl;

  localparam int WIDTH      = 10;
  localparam int ADDR_W     = 4;
  localparam int DEPTH      = 16;
  localparam int AEMPTY_VAL = 2;
  localparam int AFULL_VAL  = 14;

  logic              clk;
  logic              reset;
  logic              wr_en;
  logic [WIDTH-1:0]  din;
  logic              fifo_rd_en;
  logic [WIDTH-1:0]  fifo_dout;
  logic              fifo_empty;
  logic              fifo_aempty;
  logic              full;
  logic              afull;
  logic [ADDR_W-1:0] fifo_MEMRADDR;
  logic [ADDR_W:0]   wr_count;
  logic              overflow;
  logic              underflow;

  int compared;
  int mismatched;

  // Behavioural model: contents as a queue, reads counted to track the address.
  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] model_dout;
  int               model_reads;
  bit               model_ovf;
  bit               model_unf;

  typedef struct {
    bit               rst;
    bit               wr;
    logic [WIDTH-1:0] data;
    bit               rd;
    logic [WIDTH-1:0] exp_dout;
    int               exp_count;
    bit               exp_empty;
    bit               exp_ovf;
    bit               exp_unf;
  } vec_t;

  vec_t vecs[11];

  corefifo_sync_ctrl #(
    .WIDTH     (WIDTH),
    .ADDR_W    (ADDR_W),
    .AEMPTY_VAL(AEMPTY_VAL),
    .AFULL_VAL (AFULL_VAL),
    .WRITE_LOW (0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .din          (din),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_dout    (fifo_dout),
    .fifo_empty   (fifo_empty),
    .fifo_aempty  (fifo_aempty),
    .full         (full),
    .afull        (afull),
    .fifo_MEMRADDR(fifo_MEMRADDR),
    .wr_count     (wr_count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model update from the pre-edge state, using the FIFO's acceptance rules.
  task automatic model_step(input bit rst, input bit wr, input logic [WIDTH-1:0] data, input bit rd);
    int  n;
    bit  was_full;
    bit  was_empty;
    n = model_q.size();
    was_full  = (n == DEPTH);
    was_empty = (n == 0);
    if (rst) begin
      model_q.delete();
      model_dout  = '0;
      model_reads = 0;
      model_ovf   = 1'b0;
      model_unf   = 1'b0;
    end else begin
      if (rd && !was_empty) begin
        model_dout = model_q.pop_front();
        model_reads++;
      end
      if (wr && !was_full) begin
        model_q.push_back(data);
      end
      model_ovf = wr && was_full;
      model_unf = rd && was_empty;
    end
  endtask

  task automatic check_model();
    int n;
    n = model_q.size();
    check_output("dout", int'(fifo_dout), int'(model_dout));
    check_output("wr_count", int'(wr_count), n);
    check_output("empty", int'(fifo_empty), int'(n == 0));
    check_output("aempty", int'(fifo_aempty), int'(n <= AEMPTY_VAL));
    check_output("full", int'(full), int'(n == DEPTH));
    check_output("afull", int'(afull), int'(n >= AFULL_VAL));
    check_output("memraddr", int'(fifo_MEMRADDR), model_reads % DEPTH);
    check_output("overflow", int'(overflow), int'(model_ovf));
    check_output("underflow", int'(underflow), int'(model_unf));
  endtask

  task automatic apply_stimulus(input bit rst, input bit wr, input logic [WIDTH-1:0] data, input bit rd);
    reset      = rst;
    wr_en      = wr;
    din        = data;
    fifo_rd_en = rd;
    model_step(rst, wr, data, rd);
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    model_dout = '0;
    model_reads = 0;
    reset = 1'b1;
    wr_en = 1'b0;
    din = '0;
    fifo_rd_en = 1'b0;

    //             rst wr  data     rd  dout     cnt emp ovf unf
    vecs[0]  = '{1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 10'h000, 1'b1, 10'h000, 0, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 10'h155, 1'b0, 10'h000, 1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 10'h0AA, 1'b1, 10'h155, 1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 10'h000, 1'b1, 10'h0AA, 0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 10'h000, 1'b1, 10'h0AA, 0, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 10'h3AA, 1'b1, 10'h0AA, 1, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 10'h000, 1'b1, 10'h3AA, 0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 10'h111, 1'b1, 10'h000, 0, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i].rst, vecs[i].wr, vecs[i].data, vecs[i].rd);
      check_output($sformatf("vec%0d_dout", i), int'(fifo_dout), int'(vecs[i].exp_dout));
      check_output($sformatf("vec%0d_count", i), int'(wr_count), vecs[i].exp_count);
      check_output($sformatf("vec%0d_empty", i), int'(fifo_empty), int'(vecs[i].exp_empty));
      check_output($sformatf("vec%0d_ovf", i), int'(overflow), int'(vecs[i].exp_ovf));
      check_output($sformatf("vec%0d_unf", i), int'(underflow), int'(vecs[i].exp_unf));
    end

    // Fill to full, then one rejected write.
    for (int i = 1; i <= 16; i++) begin
      apply_stimulus(1'b0, 1'b1, WIDTH'(i), 1'b0);
      if (i == 14) check_output("afull_at_14", int'(afull), 1);
    end
    check_output("full_after_16", int'(full), 1);
    apply_stimulus(1'b0, 1'b1, 10'h3FF, 1'b0);
    check_output("overflow_17th", int'(overflow), 1);
    check_output("count_stays_16", int'(wr_count), 16);

    // Drain in order.
    for (int i = 1; i <= 16; i++) begin
      apply_stimulus(1'b0, 1'b0, '0, 1'b1);
      check_output("drain_data", int'(fifo_dout), i);
    end
    check_output("empty_after_drain", int'(fifo_empty), 1);

    // Address wrap: pointers start at 0 after the drain.
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 1'b1, WIDTH'(10'h100 + i), 1'b0);
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 12; i++) apply_stimulus(1'b0, 1'b1, WIDTH'(10'h200 + i), 1'b0);
    for (int i = 0; i < 12; i++) apply_stimulus(1'b0, 1'b0, '0, 1'b1);
    check_output("wrap_last_data", int'(fifo_dout), 10'h20B);

    // Simultaneous read and write at count 5.
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b1, WIDTH'(10'h050 + i), 1'b0);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b0, 1'b1, WIDTH'(10'h060 + i), 1'b1);
      check_output("rw_count_5", int'(wr_count), 5);
    end
    while (model_q.size() < DEPTH) apply_stimulus(1'b0, 1'b1, WIDTH'($urandom), 1'b0);
    apply_stimulus(1'b0, 1'b1, 10'h2EE, 1'b1);
    check_output("full_rw_ovf", int'(overflow), 1);
    check_output("full_rw_count", int'(wr_count), 15);

    // Reset mid-stream at count 7.
    while (model_q.size() > 7) apply_stimulus(1'b0, 1'b0, '0, 1'b1);
    apply_stimulus(1'b1, 1'b0, '0, 1'b0);
    check_output("midrst_dout", int'(fifo_dout), 0);
    check_output("midrst_count", int'(wr_count), 0);
    apply_stimulus(1'b0, 1'b1, 10'h3AA, 1'b0);
    apply_stimulus(1'b0, 1'b0, '0, 1'b1);
    check_output("midrst_readback", int'(fifo_dout), 10'h3AA);

    // Randomized traffic with shifting write/read bias and rare resets.
    for (int i = 0; i < 3000; i++) begin
      int wp;
      int rp;
      case ((i / 250) % 3)
        0: begin wp = 70; rp = 30; end
        1: begin wp = 30; rp = 70; end
        default: begin wp = 50; rp = 50; end
      endcase
      apply_stimulus(($urandom_range(0, 399) == 0),
                     ($urandom_range(0, 99) < wp),
                     WIDTH'($urandom),
                     ($urandom_range(0, 99) < rp));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
